// File: rtl/cube_pkg.sv
// Shared types for the cube move sequencer: faces, move word, scancodes, FSM states.
package cube_pkg;

  typedef enum logic [2:0] {
    FACE_F = 3'd0, FACE_B = 3'd1, FACE_L = 3'd2,
    FACE_R = 3'd3, FACE_U = 3'd4, FACE_D = 3'd5
  } face_e;

  typedef struct packed {
    logic  prime;
    face_e face;
  } move_t;

  typedef struct packed {
    logic  hit;
    face_e face;
  } key_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_U     = 8'h3C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_ISSUE, ST_REDRAW, ST_WAIT_DRAW
  } seq_state_e;

  function automatic key_t key_lookup(input logic [7:0] sc);
    key_t k;
    k.hit  = 1'b1;
    k.face = FACE_F;
    case (sc)
      SC_F:    k.face = FACE_F;
      SC_B:    k.face = FACE_B;
      SC_L:    k.face = FACE_L;
      SC_R:    k.face = FACE_R;
      SC_U:    k.face = FACE_U;
      SC_D:    k.face = FACE_D;
      default: k.hit  = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cube_move_sequencer_if.sv
// Move handshake between the sequencer (master) and the cube logic unit (slave).
interface cube_move_sequencer_if;
  logic [3:0] move_code;
  logic       move_valid;
  logic       move_ready;

  modport master (output move_code, output move_valid, input move_ready);
  modport slave  (input move_code, input move_valid, output move_ready);
endinterface

// File: rtl/cube_move_fifo.sv
// Synchronous move FIFO; a push into a full FIFO is accepted only alongside a pop.
module cube_move_fifo
  import cube_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  move_t                  push_data,
  input  logic                   pop,
  output move_t                  pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  move_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cube_move_sequencer.sv
// Scancode decoder + move queue + issue/redraw sequencer for the cube display.
// Optional draw_done watchdog enabled by CUBE_MOVE_SEQ_TIMEOUT_EN.
module cube_move_sequencer
  import cube_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
`ifdef CUBE_MOVE_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [7:0]                  scancode,
  input  logic                        ps2_rec,
  input  logic                        prime,
  cube_move_sequencer_if.master       mv,
  output logic                        redraw,
  input  logic                        draw_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
`ifdef CUBE_MOVE_SEQ_TIMEOUT_EN
  , output logic                      draw_timeout
`endif
);

  seq_state_e state, state_n;
  move_t      head, push_data_q, code_q, code_n;
  logic       push_q, pop, full, empty;
  logic       valid_q, valid_n, redraw_n, timeout_hit;
  logic       brk, ext;
  logic [7:0] held;
  key_t       key;

  assign key = key_lookup(scancode);

  cube_move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // held tracks the last make code so typematic repeats don't re-enqueue; 8'h00 = none.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      held        <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (ps2_rec) begin
        if (scancode == SC_BREAK) brk <= 1'b1;
        else if (scancode == SC_EXT) ext <= 1'b1;
        else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (scancode == held) held <= 8'h00;
        end else if (ext) ext <= 1'b0;
        else if (key.hit && scancode != held) begin
          held        <= scancode;
          push_q      <= 1'b1;
          push_data_q <= '{prime: prime, face: key.face};
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                     overflow <= 1'b0;
    else if (push_q && full && !pop) overflow <= 1'b1;
  end

  always_comb begin
    state_n  = state;
    code_n   = code_q;
    valid_n  = valid_q;
    redraw_n = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_INIT: begin
        redraw_n = 1'b1;
        state_n  = ST_WAIT_DRAW;
      end
      ST_IDLE: if (!empty) begin
        code_n  = head;
        valid_n = 1'b1;
        pop     = 1'b1;
        state_n = ST_ISSUE;
      end
      ST_ISSUE: if (mv.move_ready) begin
        valid_n  = 1'b0;
        redraw_n = 1'b1;
        state_n  = ST_REDRAW;
      end
      ST_REDRAW:    state_n = ST_WAIT_DRAW;
      ST_WAIT_DRAW: if (draw_done || timeout_hit) state_n = ST_IDLE;
      default:      state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      code_q  <= '0;
      valid_q <= 1'b0;
      redraw  <= 1'b0;
    end else begin
      state   <= state_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      redraw  <= redraw_n;
    end
  end

  assign mv.move_code  = code_q;
  assign mv.move_valid = valid_q;
  assign busy          = (state != ST_IDLE);

`ifdef CUBE_MOVE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state == ST_WAIT_DRAW) && !draw_done &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      to_cnt       <= '0;
      draw_timeout <= 1'b0;
    end else begin
      to_cnt <= (state == ST_WAIT_DRAW && state_n == ST_WAIT_DRAW) ? to_cnt + 1'b1 : '0;
      if (timeout_hit) draw_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/cube_move_sequencer.md
Name: cube_move_sequencer

Overview:
Sits between the PS/2 keyboard receiver, the cube logic unit and the cube drawer. It decodes keyboard scancodes into face-turn moves and queues them in a small FIFO. It issues one move at a time to the logic unit over a valid/ready handshake, then triggers a full redraw. The next move is not issued until the drawer reports completion, so state updates never race the pixel writer.

Parameters:
FIFO_DEPTH, 8, move queue entries (power of two, ≥2)
TIMEOUT_CYCLES, 2000000, draw_done watchdog limit in CLOCK_50 cycles (used only with optional feature)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
scancode  in  8  byte from PS/2 receiver
ps2_rec  in  1  one-cycle strobe: scancode valid
prime  in  1  level, sampled on accepted make code; 1 = counter-clockwise turn
move_code  out  4  {prime, face[2:0]}
move_valid  out  1  move offered to logic unit
move_ready  in  1  logic unit accepts move (transfer when valid&&ready)
redraw  out  1  one-cycle pulse to drawer
draw_done  in  1  one-cycle pulse from drawer: frame fully plotted
busy  out  1  high in any state other than IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued moves
overflow  out  1  sticky: a move was dropped because the FIFO was full

Behaviour:
- Reset values: move_code=0, move_valid=0, redraw=0, busy=1, fifo_count=0, overflow=0; FIFO pointers 0; decoder flags clear; held-key register empty; FSM=INIT.
- Face encoding: F=0, B=1, L=2, R=3, U=4, D=5. Key map (set 2 make codes): 0x2B→F, 0x32→B, 0x4B→L, 0x2D→R, 0x3C→U, 0x23→D. All other codes are ignored.
- Decoder, acts only on ps2_rec:
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - Any other byte with brk set: clears brk, clears ext, clears held if the byte equals held; no enqueue.
  - Any other byte with ext set (brk clear): clears ext; no enqueue.
  - Otherwise, for a mapped code: if it equals held, it is a typematic repeat and is ignored. Else held := byte and the move {prime, face} is enqueued.
- Enqueue latency: a FIFO write occurs on the cycle after the ps2_rec strobe. fifo_count updates on the same edge as the write.
- FIFO full on enqueue: the move is dropped and overflow is set. Exception: if a dequeue occurs on the same edge, the write is accepted and count is unchanged.
- FSM:
  - INIT: pulse redraw for 1 cycle → WAIT_DRAW (draws the initial cube).
  - IDLE: if fifo_count≠0, load the head into move_code, assert move_valid, pop → ISSUE.
  - ISSUE: hold move_valid and move_code stable until move_ready. On the handshake cycle move_valid drops on the next edge → REDRAW.
  - REDRAW: redraw=1 for exactly one cycle → WAIT_DRAW.
  - WAIT_DRAW: wait for draw_done → IDLE.
- A draw_done arriving in any state other than WAIT_DRAW is ignored.
- Minimum issue spacing: a new move_valid asserts no earlier than 1 cycle after draw_done.
- Enqueue continues in every state, including INIT, ISSUE and WAIT_DRAW.
- Reset asserted mid-operation returns everything to reset values immediately. Queued moves are discarded and the first action after release is the INIT redraw.

Optional Feature:
Macro CUBE_MOVE_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DRAW. When it reaches TIMEOUT_CYCLES without draw_done, the FSM returns to IDLE and the sticky output draw_timeout (1 bit, reset 0) is set.
- Undefined: no counter and no draw_timeout port; WAIT_DRAW waits indefinitely.

Decomposition:
- Package cube_pkg holds:
  - face enum (FACE_F..FACE_D)
  - move_t packed struct {prime, face}
  - scancode constants (SC_BREAK=8'hF0, SC_EXT=8'hE0, the six key codes)
  - FSM state enum
- One sub-module is natural: cube_move_fifo, a synchronous FIFO parameterised by depth. It has push/pop/full/empty/count and defined simultaneous push+pop when full.

Test Plan:
- Reset release, draw_done after 10 cycles → redraw pulse 1 cycle after reset release; busy falls the cycle after draw_done.
- Bytes 0x3C, F0, 3C with prime=0, move_ready tied high → one move_code=4'h4 handshake, one redraw pulse, fifo_count back to 0.
- 0x2D ×5 (typematic) then F0 2D, prime=1 → exactly one move 4'hB issued.
- 0xE0 0x2B, then 0xE0 0xF0 0x2B → no enqueue, fifo_count stays 0.
- Drawer stalled (no draw_done), 9 distinct make/break pairs, FIFO_DEPTH=8 → fifo_count=8, overflow=1; after draw_done pulses, the 8 moves are issued in arrival order.
- Reset pulsed while in ISSUE with 3 queued → move_valid=0 and fifo_count=0 immediately; INIT redraw follows release.
